biquad_cfg_ctrl: RTL and testbench
==================================

// Module: biquad_cfg_ctrl
// PURPOSE
//  Coefficient configuration controller for a cascade of N_SECT u16_biquad sections.
//  Host writes coefficients into a shadow bank over a valid/ready word port.
//  A COMMIT copies the whole shadow bank to the active bank atomically, on the next sample tick.
//  Optionally it then flushes the biquad delay state by pulsing the biquad reset.
// PARAMETERS
//  N_SECT     4   number of cascaded biquad sections served
//  COEF_W     16  coefficient width, signed (matches biquad b_0..a_2 ports)
//  FLUSH_CYC  2   cycles FILT_RST is held low for a flush (>=1)
//  SW         $clog2(N_SECT) (min 1)  section-address width (localparam)
// PORTS
//  CLK        in   1            single clock, all logic on rising edge
//  RST        in   1            reset, synchronous and active-low
//  WR_VALID   in   1            coefficient write request
//  WR_READY   out  1            write accepted when WR_VALID&&WR_READY
//  WR_SECT    in   SW           target section
//  WR_IDX     in   3            0=b_0 1=b_1 2=b_2 3=a_1 4=a_2; 5..7 illegal
//  WR_DATA    in   COEF_W       signed coefficient value
//  COMMIT     in   1            request shadow->active swap (level sampled in IDLE)
//  FLUSH_REQ  in   1            sampled with COMMIT; 1 = flush filter state after swap
//  SMP_TICK   in   1            one-cycle sample-boundary strobe from sample-rate timing
//  BUSY       out  1            commit pending or flush in progress
//  SWAP_DONE  out  1            one-cycle pulse: active bank just updated
//  ERR        out  1            sticky: an illegal write was dropped
//  FILT_RST   out  1            active-low reset to all biquad sections
//  COEF_B0    out  N_SECT*COEF_W  active b_0, section k at [k*COEF_W +: COEF_W]
//  COEF_B1/COEF_B2/COEF_A1/COEF_A2  out  N_SECT*COEF_W  same packing
// BEHAVIOUR
//  Reset (RST=0 at edge): state=IDLE; shadow+active all 0; BUSY=0 SWAP_DONE=0 ERR=0;
//   FILT_RST=0 (registered) while RST low, 1 from first edge after RST high.
//  States: IDLE, WAIT_SMP, FLUSH. WR_READY=1 only in IDLE (registered-state decode).
//  IDLE: accepted write updates shadow[WR_SECT][WR_IDX] at that edge; active unaffected.
//   WR_IDX>4 or WR_SECT>=N_SECT: write consumed (handshake completes), data dropped, ERR<=1.
//   COMMIT=1: latch flush_pend<=FLUSH_REQ, ->WAIT_SMP, BUSY=1 next cycle.
//   COMMIT+accepted write same cycle: write lands in shadow and is included in the swap.
//   SMP_TICK in the COMMIT cycle is ignored; swap waits for a later tick.
//  WAIT_SMP: COMMIT/WR_VALID ignored (WR_READY=0). On SMP_TICK at edge u:
//   all active<=shadow in that edge (visible cycle u+1), SWAP_DONE=1 during u+1 only;
//   flush_pend=0 -> IDLE, BUSY=0 from u+1; flush_pend=1 -> FLUSH, counter<=FLUSH_CYC-1.
//  FLUSH: FILT_RST=0 for exactly FLUSH_CYC cycles (u+1..u+FLUSH_CYC), counter down to 0,
//   then IDLE; BUSY=0 and FILT_RST=1 from u+FLUSH_CYC+1.
//  Shadow bank retains values after swap (incremental edits allowed).
//  Reset mid-WAIT_SMP/FLUSH: abandoned, pending swap lost, all banks return to 0.
//  ERR clears only on reset. Active bank never changes except at a swap edge or reset.
//  No arithmetic; coefficients pass bit-exact, two's complement, no saturation.
// STRUCTURE
//  Shared package/header biquad_cfg_pkg: COEF_W default, IDX_B0..IDX_A2 constants,
//   IDX_LAST=4, state encodings ST_IDLE/ST_WAIT/ST_FLUSH.
//  Sub-module biquad_coef_bank: one section's 5 shadow + 5 active regs, write-enable+idx,
//   swap input; instantiated N_SECT times via generate. FSM+counter+ERR in top.
// TESTING
//  1 Reset: hold RST=0 3 cycles -> all COEF_* 0, FILT_RST=0, WR_READY=0; release -> WR_READY=1, FILT_RST=1.
//  2 Write sect1 b_0=16'sh4000, a_1=-16'sd1234 -> COEF_* unchanged; COMMIT, tick 5 cycles later ->
//    COEF_B0[31:16]=16'h4000, COEF_A1[31:16]=16'hFB2E the cycle after tick, SWAP_DONE 1 cycle, BUSY low.
//  3 COMMIT with FLUSH_REQ=1, FLUSH_CYC=2 -> FILT_RST low exactly 2 cycles after tick, BUSY drops next.
//  4 Write WR_IDX=6 data 16'h7FFF -> handshake completes, ERR=1 sticky, no bank change;
//    WR_SECT=3 with N_SECT=3 -> same.
//  5 Simultaneous: write+COMMIT+SMP_TICK same cycle -> no swap that tick; swap at next tick includes write;
//    WR_VALID during WAIT_SMP stalls (WR_READY=0) then accepted after return to IDLE.
//  6 RST low during WAIT_SMP and during FLUSH -> IDLE, banks 0, BUSY=0, no SWAP_DONE.

Source files
------------

// File: rtl/biquad_cfg_pkg.sv
// Shared constants for the biquad coefficient configuration controller:
// coefficient index map and controller state encoding.
package biquad_cfg_pkg;

  localparam int COEF_W_DEF = 16;

  localparam logic [2:0] IDX_B0   = 3'd0;
  localparam logic [2:0] IDX_B1   = 3'd1;
  localparam logic [2:0] IDX_B2   = 3'd2;
  localparam logic [2:0] IDX_A1   = 3'd3;
  localparam logic [2:0] IDX_A2   = 3'd4;
  localparam logic [2:0] IDX_LAST = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/biquad_cfg_ctrl_if.sv
// Host coefficient write port: one valid/ready word transfer per accepted beat.
interface biquad_cfg_ctrl_if
  import biquad_cfg_pkg::*;
#(
  parameter int SW     = 2,
  parameter int COEF_W = COEF_W_DEF
);
  logic                     WR_VALID;
  logic                     WR_READY;
  logic [SW-1:0]            WR_SECT;
  logic [2:0]               WR_IDX;
  logic signed [COEF_W-1:0] WR_DATA;

  modport master (output WR_VALID, WR_SECT, WR_IDX, WR_DATA, input WR_READY);
  modport slave  (input WR_VALID, WR_SECT, WR_IDX, WR_DATA, output WR_READY);
endinterface

// File: rtl/biquad_coef_bank.sv
// One biquad section's coefficients: five shadow registers written by the host
// and five active registers loaded from the shadow set in a single swap edge.
module biquad_coef_bank
  import biquad_cfg_pkg::*;
#(
  parameter int COEF_W = COEF_W_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  logic [2:0]               idx_i,
  input  logic signed [COEF_W-1:0] data_i,
  input  logic                     swap_i,
  output logic signed [COEF_W-1:0] b0_o,
  output logic signed [COEF_W-1:0] b1_o,
  output logic signed [COEF_W-1:0] b2_o,
  output logic signed [COEF_W-1:0] a1_o,
  output logic signed [COEF_W-1:0] a2_o
);

  logic signed [COEF_W-1:0] shd_q [5];
  logic signed [COEF_W-1:0] act_q [5];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < 5; k++) begin
        shd_q[k] <= '0;
        act_q[k] <= '0;
      end
    end else begin
      // idx_i is pre-qualified by the controller; 5..7 never arrive with we_i
      if (we_i) begin
        case (idx_i)
          IDX_B0:  shd_q[0] <= data_i;
          IDX_B1:  shd_q[1] <= data_i;
          IDX_B2:  shd_q[2] <= data_i;
          IDX_A1:  shd_q[3] <= data_i;
          IDX_A2:  shd_q[4] <= data_i;
          default: ;
        endcase
      end
      if (swap_i) begin
        for (int k = 0; k < 5; k++) act_q[k] <= shd_q[k];
      end
    end
  end

  assign b0_o = act_q[0];
  assign b1_o = act_q[1];
  assign b2_o = act_q[2];
  assign a1_o = act_q[3];
  assign a2_o = act_q[4];

endmodule

// File: rtl/biquad_cfg_ctrl.sv
// Coefficient configuration controller: shadow writes, sample-aligned atomic
// shadow->active commit, and optional biquad state flush afterwards.
module biquad_cfg_ctrl
  import biquad_cfg_pkg::*;
#(
  parameter int N_SECT    = 4,
  parameter int COEF_W    = COEF_W_DEF,
  parameter int FLUSH_CYC = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  biquad_cfg_ctrl_if.slave           wr,
  input  logic                       COMMIT,
  input  logic                       FLUSH_REQ,
  input  logic                       SMP_TICK,
  output logic                       BUSY,
  output logic                       SWAP_DONE,
  output logic                       ERR,
  output logic                       FILT_RST,
  output logic [N_SECT*COEF_W-1:0]   COEF_B0,
  output logic [N_SECT*COEF_W-1:0]   COEF_B1,
  output logic [N_SECT*COEF_W-1:0]   COEF_B2,
  output logic [N_SECT*COEF_W-1:0]   COEF_A1,
  output logic [N_SECT*COEF_W-1:0]   COEF_A2
);

  localparam int SW = (N_SECT > 1) ? $clog2(N_SECT) : 1;
  localparam int CW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [SW:0] SECT_LIM = (SW+1)'(N_SECT);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flush_pend_q, flush_pend_d;
  logic          err_q, err_d;
  logic          swap_done_q, swap_done_d;
  logic          filt_rst_q, filt_rst_d;
  logic          live_q;
  logic          wr_ready, wr_fire, wr_legal, swap;
  logic [SW-1:0] sect;

  assign sect     = wr.WR_SECT;
  // live_q keeps the port closed while reset is held
  assign wr_ready = live_q && (state_q == ST_IDLE);
  assign wr_fire  = wr.WR_VALID && wr_ready;
  assign wr_legal = (wr.WR_IDX <= IDX_LAST) && ({1'b0, sect} < SECT_LIM);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    swap         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (COMMIT) begin
          flush_pend_d = FLUSH_REQ;
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (SMP_TICK) begin
          swap    = 1'b1;
          state_d = flush_pend_q ? ST_FLUSH : ST_IDLE;
          cnt_d   = CW'(FLUSH_CYC - 1);
        end
      end
      ST_FLUSH: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    swap_done_d = swap;
    filt_rst_d  = (state_d != ST_FLUSH);
    err_d       = err_q || (wr_fire && !wr_legal);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      err_q        <= 1'b0;
      swap_done_q  <= 1'b0;
      filt_rst_q   <= 1'b0;
      live_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      err_q        <= err_d;
      swap_done_q  <= swap_done_d;
      filt_rst_q   <= filt_rst_d;
      live_q       <= 1'b1;
    end
  end

  assign wr.WR_READY = wr_ready;
  assign BUSY        = (state_q != ST_IDLE);
  assign SWAP_DONE   = swap_done_q;
  assign ERR         = err_q;
  assign FILT_RST    = filt_rst_q;

  for (genvar k = 0; k < N_SECT; k++) begin : g_sect
    logic we;
    assign we = wr_fire && wr_legal && (sect == SW'(k));
    biquad_coef_bank #(.COEF_W(COEF_W)) u_bank (
      .clk_i  (CLK),
      .rst_ni (RST),
      .we_i   (we),
      .idx_i  (wr.WR_IDX),
      .data_i (wr.WR_DATA),
      .swap_i (swap),
      .b0_o   (COEF_B0[k*COEF_W +: COEF_W]),
      .b1_o   (COEF_B1[k*COEF_W +: COEF_W]),
      .b2_o   (COEF_B2[k*COEF_W +: COEF_W]),
      .a1_o   (COEF_A1[k*COEF_W +: COEF_W]),
      .a2_o   (COEF_A2[k*COEF_W +: COEF_W])
    );
  end

endmodule

// File: tb/tb_biquad_cfg_ctrl.sv
// Directed table-driven bench for biquad_cfg_ctrl (3 sections, 16-bit coefs, 2-cycle flush).
module tb_biquad_cfg_ctrl;
  import biquad_cfg_pkg::*;

  localparam int NS = 3;
  localparam int CWD = 16;
  localparam int BW = NS*CWD;

  logic clk = 1'b0;
  logic rst_n;
  logic commit, flush_req, smp_tick;
  logic busy, swap_done, err, filt_rst;
  logic [BW-1:0] b0, b1, b2, a1, a2;

  biquad_cfg_ctrl_if #(.SW(2), .COEF_W(CWD)) wr ();

  biquad_cfg_ctrl #(.N_SECT(NS), .COEF_W(CWD), .FLUSH_CYC(2)) dut (
    .CLK(clk), .RST(rst_n), .wr(wr),
    .COMMIT(commit), .FLUSH_REQ(flush_req), .SMP_TICK(smp_tick),
    .BUSY(busy), .SWAP_DONE(swap_done), .ERR(err), .FILT_RST(filt_rst),
    .COEF_B0(b0), .COEF_B1(b1), .COEF_B2(b2), .COEF_A1(a1), .COEF_A2(a2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, v;
    logic [1:0]  s;
    logic [2:0]  i;
    logic [15:0] d;
    logic        c, f, t;
    logic        rdy, busy, swp, err, frst;
    logic [47:0] b0, a1;
  } vec_t;

  vec_t vecs[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, v, input logic [1:0] s, input logic [2:0] i,
                              input logic [15:0] d, input logic c, f, t,
                              input logic rdy, bsy, swp, er, frst,
                              input logic [47:0] eb0, ea1);
    vec_t x;
    x.rst = rst; x.v = v; x.s = s; x.i = i; x.d = d; x.c = c; x.f = f; x.t = t;
    x.rdy = rdy; x.busy = bsy; x.swp = swp; x.err = er; x.frst = frst;
    x.b0 = eb0; x.a1 = ea1;
    return x;
  endfunction

  task automatic drive(input logic rst, v, input logic [1:0] s, input logic [2:0] i,
                       input logic [15:0] d, input logic c, f, t);
    rst_n = rst; wr.WR_VALID = v; wr.WR_SECT = s; wr.WR_IDX = i; wr.WR_DATA = d;
    commit = c; flush_req = f; smp_tick = t;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [47:0] B0_S1 = 48'h0000_4000_0000;
  localparam logic [47:0] A1_S1 = 48'h0000_FB2E_0000;
  localparam logic [47:0] B0_T5 = 48'h0000_4000_1234;
  localparam logic [47:0] A1_T5 = 48'h8000_FB2E_0000;
  localparam logic [47:0] B0_42 = 48'h0000_0042_0000;

  logic [47:0] exp_bank [5];
  logic [15:0] wd;

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    // reset held three cycles, then release
    for (int k = 0; k < 3; k++) vecs.push_back(mk(0,0,0,0,16'h0,0,0,0, 0,0,0,0,0, 0,0));
    vecs.push_back(mk(1,0,0,0,16'h0,0,0,0, 1,0,0,0,1, 0,0));
    // shadow writes do not touch active bank; commit, tick five cycles later
    vecs.push_back(mk(1,1,1,IDX_B0,16'h4000,0,0,0, 1,0,0,0,1, 0,0));
    vecs.push_back(mk(1,1,1,IDX_A1,16'hFB2E,0,0,0, 1,0,0,0,1, 0,0));
    vecs.push_back(mk(1,0,0,0,16'h0,1,0,0, 0,1,0,0,1, 0,0));
    for (int k = 0; k < 4; k++) vecs.push_back(mk(1,0,0,0,16'h0,0,0,0, 0,1,0,0,1, 0,0));
    vecs.push_back(mk(1,0,0,0,16'h0,0,0,1, 1,0,1,0,1, B0_S1,A1_S1));
    vecs.push_back(mk(1,0,0,0,16'h0,0,0,0, 1,0,0,0,1, B0_S1,A1_S1));
    // commit with flush: FILT_RST low exactly two cycles
    vecs.push_back(mk(1,0,0,0,16'h0,1,1,0, 0,1,0,0,1, B0_S1,A1_S1));
    vecs.push_back(mk(1,0,0,0,16'h0,0,0,1, 0,1,1,0,0, B0_S1,A1_S1));
    vecs.push_back(mk(1,0,0,0,16'h0,0,0,0, 0,1,0,0,0, B0_S1,A1_S1));
    vecs.push_back(mk(1,0,0,0,16'h0,0,0,0, 1,0,0,0,1, B0_S1,A1_S1));
    // illegal writes: bad index, bad section
    vecs.push_back(mk(1,1,1,3'd6,16'h7FFF,0,0,0, 1,0,0,1,1, B0_S1,A1_S1));
    vecs.push_back(mk(1,1,3,IDX_B0,16'h1111,0,0,0, 1,0,0,1,1, B0_S1,A1_S1));
    vecs.push_back(mk(1,0,0,0,16'h0,1,0,0, 0,1,0,1,1, B0_S1,A1_S1));
    vecs.push_back(mk(1,0,0,0,16'h0,0,0,1, 1,0,1,1,1, B0_S1,A1_S1));
    // write+commit+tick together; write stalled during WAIT
    vecs.push_back(mk(1,1,0,IDX_B0,16'h1234,1,0,1, 0,1,0,1,1, B0_S1,A1_S1));
    vecs.push_back(mk(1,1,2,IDX_A1,16'h8000,0,0,0, 0,1,0,1,1, B0_S1,A1_S1));
    vecs.push_back(mk(1,1,2,IDX_A1,16'h8000,0,0,1, 1,0,1,1,1, B0_T5,A1_S1));
    vecs.push_back(mk(1,1,2,IDX_A1,16'h8000,0,0,0, 1,0,0,1,1, B0_T5,A1_S1));
    vecs.push_back(mk(1,0,0,0,16'h0,1,0,0, 0,1,0,1,1, B0_T5,A1_S1));
    vecs.push_back(mk(1,0,0,0,16'h0,0,0,1, 1,0,1,1,1, B0_T5,A1_T5));
    // reset during WAIT_SMP
    vecs.push_back(mk(1,0,0,0,16'h0,1,0,0, 0,1,0,1,1, B0_T5,A1_T5));
    vecs.push_back(mk(0,0,0,0,16'h0,0,0,0, 0,0,0,0,0, 0,0));
    vecs.push_back(mk(1,0,0,0,16'h0,0,0,0, 1,0,0,0,1, 0,0));
    vecs.push_back(mk(1,0,0,0,16'h0,0,0,1, 1,0,0,0,1, 0,0));
    // reset during FLUSH
    vecs.push_back(mk(1,1,1,IDX_B0,16'h0042,0,0,0, 1,0,0,0,1, 0,0));
    vecs.push_back(mk(1,0,0,0,16'h0,1,1,0, 0,1,0,0,1, 0,0));
    vecs.push_back(mk(1,0,0,0,16'h0,0,0,1, 0,1,1,0,0, B0_42,0));
    vecs.push_back(mk(0,0,0,0,16'h0,0,0,0, 0,0,0,0,0, 0,0));
    vecs.push_back(mk(1,0,0,0,16'h0,0,0,0, 1,0,0,0,1, 0,0));

    for (int r = 0; r < vecs.size(); r++) begin
      drive(vecs[r].rst, vecs[r].v, vecs[r].s, vecs[r].i, vecs[r].d,
            vecs[r].c, vecs[r].f, vecs[r].t);
      step();
      chk($sformatf("row%0d WR_READY", r),  48'(wr.WR_READY), 48'(vecs[r].rdy));
      chk($sformatf("row%0d BUSY", r),      48'(busy),        48'(vecs[r].busy));
      chk($sformatf("row%0d SWAP_DONE", r), 48'(swap_done),   48'(vecs[r].swp));
      chk($sformatf("row%0d ERR", r),       48'(err),         48'(vecs[r].err));
      chk($sformatf("row%0d FILT_RST", r),  48'(filt_rst),    48'(vecs[r].frst));
      chk($sformatf("row%0d COEF_B0", r),   b0,               vecs[r].b0);
      chk($sformatf("row%0d COEF_A1", r),   a1,               vecs[r].a1);
    end

    // full sweep: every section and index, then one atomic swap
    for (int k = 0; k < 5; k++) exp_bank[k] = '0;
    for (int s = 0; s < NS; s++) begin
      for (int i = 0; i < 5; i++) begin
        wd = 16'h8000 | 16'(s << 8) | 16'(i * 16'h11);
        exp_bank[i][s*CWD +: CWD] = wd;
        drive(1, 1, 2'(s), 3'(i), wd, 0, 0, 0);
        step();
      end
    end
    drive(1, 0, 0, 0, 16'h0, 1, 0, 0);
    step();
    chk("sweep pre-swap B1", b1, 48'h0);
    drive(1, 0, 0, 0, 16'h0, 0, 0, 1);
    step();
    chk("sweep SWAP_DONE", 48'(swap_done), 48'h1);
    chk("sweep COEF_B0", b0, exp_bank[0]);
    chk("sweep COEF_B1", b1, exp_bank[1]);
    chk("sweep COEF_B2", b2, exp_bank[2]);
    chk("sweep COEF_A1", a1, exp_bank[3]);
    chk("sweep COEF_A2", a2, exp_bank[4]);
    // incremental shadow edit leaves active untouched until next swap
    drive(1, 1, 0, IDX_A2, 16'h7FFF, 0, 0, 0);
    step();
    chk("edit COEF_A2 held", a2, exp_bank[4]);
    exp_bank[4][15:0] = 16'h7FFF;
    drive(1, 0, 0, 0, 16'h0, 1, 0, 0);
    step();
    drive(1, 0, 0, 0, 16'h0, 0, 0, 1);
    step();
    chk("edit COEF_A2 swapped", a2, exp_bank[4]);
    chk("edit COEF_B2 kept", b2, exp_bank[2]);
    drive(1, 0, 0, 0, 16'h0, 0, 0, 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
